// File: rtl/qspi_test_sequencer.sv
// qspi_test_sequencer: flash self-test sequencer for the QSPI command engine.
// Sequence: config write, optional erase, quad program, quad readback, compare.
module qspi_test_sequencer #(
    parameter int              ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int              NUM_BYTES  = 256,
    parameter int              POLL_MAX   = 65535,
    parameter logic [15:0]     CFG_VALUE  = 16'hAFE7,
    parameter bit              DO_ERASE   = 1'b1
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_start,
    input  logic [1:0]        I_mode,
    input  logic              I_done,
    input  logic [7:0]        I_rd_data,
    output logic [4:0]        O_cmd_type,
    output logic [7:0]        O_flash_cmd,
    output logic [ADDR_W-1:0] O_flash_addr,
    output logic [15:0]       O_status_reg,
    output logic [7:0]        O_wr_data,
    output logic              O_busy,
    output logic              O_done,
    output logic              O_pass,
    output logic              O_timeout,
    output logic [15:0]       O_err_cnt
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_WREN0 = 4'd1;
    localparam logic [3:0] S_CFG   = 4'd2;
    localparam logic [3:0] S_POLL  = 4'd3;
    localparam logic [3:0] S_WREN1 = 4'd4;
    localparam logic [3:0] S_ERASE = 4'd5;
    localparam logic [3:0] S_WRENP = 4'd6;
    localparam logic [3:0] S_PROG  = 4'd7;
    localparam logic [3:0] S_READ  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    localparam logic [16:0] LAST_IDX = 17'(NUM_BYTES - 1);
    localparam logic [16:0] POLL_LIM = 17'(POLL_MAX);

    logic [3:0]        state;
    logic [3:0]        ret_state;
    logic              gap;
    logic [16:0]       idx;
    logic [16:0]       poll_cnt;
    logic [1:0]        mode_r;
    logic              busy;
    logic              pass;
    logic              timeout;
    logic [15:0]       err_cnt;
    logic [15:0]       status_reg;

    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        pat;
    logic              cmd_ok;
    logic              mism;
    logic [15:0]       err_nxt;
    logic              last_idx;

    // Current byte address and the pattern byte expected there
    always_comb begin
        cur_addr = START_ADDR + ADDR_W'(idx);
        case (mode_r)
            2'd0:    pat = 8'h00;
            2'd1:    pat = 8'hFF;
            2'd2:    pat = cur_addr[7:0];
            default: pat = cur_addr[0] ? 8'hAA : 8'h55;
        endcase
    end

    // Command drive; forced idle during the one-cycle gap after each completion
    always_comb begin
        O_cmd_type   = 5'd0;
        O_flash_cmd  = 8'h00;
        O_flash_addr = '0;
        O_wr_data    = 8'h00;
        if (!gap) begin
            case (state)
                S_WREN0, S_WREN1, S_WRENP: begin
                    O_cmd_type  = 5'b10001;
                    O_flash_cmd = 8'h06;
                end
                S_CFG: begin
                    O_cmd_type  = 5'b10110;
                    O_flash_cmd = 8'hB1;
                end
                S_POLL: begin
                    O_cmd_type  = 5'b10011;
                    O_flash_cmd = 8'h05;
                end
                S_ERASE: begin
                    O_cmd_type   = 5'b10100;
                    O_flash_cmd  = 8'hD8;
                    O_flash_addr = cur_addr;
                end
                S_PROG: begin
                    O_cmd_type   = 5'b11000;
                    O_flash_cmd  = 8'h32;
                    O_flash_addr = cur_addr;
                    O_wr_data    = pat;
                end
                S_READ: begin
                    O_cmd_type   = 5'b11001;
                    O_flash_cmd  = 8'h6B;
                    O_flash_addr = cur_addr;
                end
                default: ;
            endcase
        end
    end

    // Completion qualifiers and saturating error update
    always_comb begin
        cmd_ok   = I_done && (O_cmd_type != 5'd0);
        mism     = (I_rd_data != pat);
        last_idx = (idx == LAST_IDX);
        err_nxt  = err_cnt;
        if (mism && (err_cnt != 16'hFFFF)) begin
            err_nxt = err_cnt + 16'd1;
        end
    end

    // Sequencer state machine
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state      <= S_IDLE;
            ret_state  <= S_IDLE;
            gap        <= 1'b0;
            idx        <= '0;
            poll_cnt   <= '0;
            mode_r     <= 2'd0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_cnt    <= 16'h0000;
            status_reg <= 16'hFFFF;
        end else begin
            gap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_start) begin
                        state      <= S_WREN0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        err_cnt    <= 16'h0000;
                        idx        <= '0;
                        poll_cnt   <= '0;
                        mode_r     <= I_mode;
                        status_reg <= CFG_VALUE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (cmd_ok) begin
                        gap <= 1'b1;
                        case (state)
                            S_WREN0: state <= S_CFG;
                            S_CFG: begin
                                state     <= S_POLL;
                                poll_cnt  <= '0;
                                ret_state <= DO_ERASE ? S_WREN1 : S_WRENP;
                            end
                            S_WREN1: state <= S_ERASE;
                            S_ERASE: begin
                                state     <= S_POLL;
                                poll_cnt  <= '0;
                                ret_state <= S_WRENP;
                            end
                            S_WRENP: state <= S_PROG;
                            S_PROG: begin
                                state    <= S_POLL;
                                poll_cnt <= '0;
                                if (last_idx) begin
                                    idx       <= '0;
                                    ret_state <= S_READ;
                                end else begin
                                    idx       <= idx + 17'd1;
                                    ret_state <= S_WRENP;
                                end
                            end
                            S_POLL: begin
                                if (!I_rd_data[0]) begin
                                    state <= ret_state;
                                end else if (poll_cnt + 17'd1 >= POLL_LIM) begin
                                    timeout <= 1'b1;
                                    pass    <= 1'b0;
                                    busy    <= 1'b0;
                                    state   <= S_DONE;
                                end else begin
                                    poll_cnt <= poll_cnt + 17'd1;
                                end
                            end
                            S_READ: begin
                                err_cnt <= err_nxt;
                                if (last_idx) begin
                                    pass  <= (err_nxt == 16'h0000) && !timeout;
                                    busy  <= 1'b0;
                                    state <= S_DONE;
                                end else begin
                                    idx <= idx + 17'd1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Registered status outputs
    always_comb begin
        O_busy       = busy;
        O_done       = (state == S_DONE);
        O_pass       = pass;
        O_timeout    = timeout;
        O_err_cnt    = err_cnt;
        O_status_reg = status_reg;
    end

endmodule
